// File: rtl/vadd_arb.sv
// Round-robin arbiter and sequencer sharing one vector adder between two requesters.
// Issues a held start to the adder, aborts it on watchdog expiry, and returns a tagged result.
module vadd_arb #(
    parameter int unsigned LANES   = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          req_i,
    input  logic [16*LANES-1:0] a0_i,
    input  logic [16*LANES-1:0] b0_i,
    input  logic [16*LANES-1:0] a1_i,
    input  logic [16*LANES-1:0] b1_i,
    output logic [1:0]          gnt_o,
    output logic [16*LANES-1:0] add_a_o,
    output logic [16*LANES-1:0] add_b_o,
    output logic                add_start_o,
    input  logic [16*LANES-1:0] add_sum_i,
    input  logic                add_v_i,
    input  logic                add_done_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic                resp_id_o,
    output logic [16*LANES-1:0] result_o,
    output logic                ovf_o,
    output logic                err_o,
    output logic                busy_o
);

    localparam int unsigned VW = 16 * LANES;
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [VW-1:0]   add_a_q, add_a_d;
    logic [VW-1:0]   add_b_q, add_b_d;
    logic            add_start_q, add_start_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_id_q, resp_id_d;
    logic [VW-1:0]   result_q, result_d;
    logic            ovf_q, ovf_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            sel;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        gnt_d        = 2'b00;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_start_d  = add_start_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        result_d     = result_q;
        ovf_d        = ovf_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        // Lone requester wins; on contention the port not served last wins
        sel          = req_i[1] & (~req_i[0] | ~last_q);

        case (state_q)
            S_IDLE: begin
                if (req_i != 2'b00) begin
                    add_a_d     = sel ? a1_i : a0_i;
                    add_b_d     = sel ? b1_i : b0_i;
                    gnt_d       = sel ? 2'b10 : 2'b01;
                    add_start_d = 1'b1;
                    last_d      = sel;
                    resp_id_d   = sel;
                    cnt_d       = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion beats the watchdog when both land on the same cycle
                if (add_done_i) begin
                    result_d     = add_sum_i;
                    ovf_d        = add_v_i;
                    err_d        = 1'b0;
                    add_start_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d     = '0;
                    ovf_d        = 1'b0;
                    err_d        = 1'b1;
                    add_start_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (resp_valid_q && resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    err_d        = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            gnt_q        <= 2'b00;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_start_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            last_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_start_q  <= add_start_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign add_a_o      = add_a_q;
    assign add_b_o      = add_b_q;
    assign add_start_o  = add_start_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign result_o     = result_q;
    assign ovf_o        = ovf_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;

endmodule
